// File: rtl/scroll_pkg.sv
// Shared constants and state type for the horizontal scroll sequencer.
package scroll_pkg;

  localparam int unsigned TILE_PX      = 96;
  localparam int unsigned WORLD_W      = 3840;
  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned MAX_PROGRESS = WORLD_W - SCREEN_W;
  localparam int unsigned SCROLL_LINE  = 320;
  localparam int unsigned MAX_STEP     = 4;

  localparam int unsigned PROG_W = 12;
  localparam int unsigned X_W    = 10;
  localparam int unsigned STEP_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAPT   = 2'd1,
    COMMIT = 2'd2,
    END    = 2'd3
  } scroll_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; the reset value of the history bit
// decides whether a level already high at reset release counts as an edge.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic q;

  // History register for the sampled level.
  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

  assign rise_c = d & ~q;

endmodule

// File: rtl/scroll_controller.sv
// Per-frame scroll sequencer: captures player state on each frame edge,
// computes a clamped forward step and commits it to the world progress.
module scroll_controller
  import scroll_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [X_W-1:0]    playerX,
  input  logic              player_right,
  input  logic [STEP_W-1:0] player_dx,
  input  logic              freeze,
  output logic [PROG_W-1:0] progress,
  output logic [STEP_W-1:0] scroll_amt,
  output logic              frame_tick,
  output logic              at_end
);

  scroll_state_t     state_q, state_d;
  logic              edge_c;
  logic              capture_c, step_en_c, commit_c;
  logic [X_W-1:0]    lat_x;
  logic              lat_right;
  logic [STEP_W-1:0] lat_dx;
  logic              lat_freeze;
  logic [STEP_W-1:0] step_q;
  logic [X_W-1:0]    over_c;
  logic [PROG_W-1:0] rem_c;
  logic [PROG_W-1:0] min_c;
  logic [STEP_W-1:0] step_c;
  logic [PROG_W-1:0] progress_next_c;

  rise_detect #(.RST_VAL(1'b1)) u_rise (
    .clk    (Clk),
    .reset  (Reset),
    .d      (frame_clk),
    .rise_c (edge_c)
  );

  // Step = min(overshoot past scroll line, player speed, max step, distance left).
  always_comb begin
    over_c = '0;
    if (lat_right && (lat_x > X_W'(SCROLL_LINE))) over_c = lat_x - X_W'(SCROLL_LINE);
    rem_c = PROG_W'(MAX_PROGRESS) - progress;
    min_c = PROG_W'(over_c);
    if (PROG_W'(lat_dx) < min_c)   min_c = PROG_W'(lat_dx);
    if (PROG_W'(MAX_STEP) < min_c) min_c = PROG_W'(MAX_STEP);
    if (rem_c < min_c)             min_c = rem_c;
    step_c = lat_freeze ? '0 : STEP_W'(min_c);
  end

  assign progress_next_c = progress + PROG_W'(step_q);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath enables; END still services edges with a zero step.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    step_en_c = 1'b0;
    commit_c  = 1'b0;
    case (state_q)
      IDLE, END: begin
        if (edge_c) begin
          state_d   = CAPT;
          capture_c = 1'b1;
        end
      end
      CAPT: begin
        state_d   = COMMIT;
        step_en_c = 1'b1;
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_d  = (progress_next_c == PROG_W'(MAX_PROGRESS)) ? END : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input capture, step register and committed outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lat_x      <= '0;
      lat_right  <= 1'b0;
      lat_dx     <= '0;
      lat_freeze <= 1'b0;
      step_q     <= '0;
      progress   <= '0;
      scroll_amt <= '0;
      frame_tick <= 1'b0;
      at_end     <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (capture_c) begin
        lat_x      <= playerX;
        lat_right  <= player_right;
        lat_dx     <= player_dx;
        lat_freeze <= freeze;
      end
      if (step_en_c) step_q <= step_c;
      if (commit_c) begin
        progress   <= progress_next_c;
        scroll_amt <= step_q;
        frame_tick <= 1'b1;
        if (progress_next_c == PROG_W'(MAX_PROGRESS)) at_end <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scroll_controller.sv
// Self-checking bench for scroll_controller: directed table, corner sequences
// and randomized frames against a simple arithmetic reference model.
module tb_scroll_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  playerX;
  logic        player_right;
  logic [2:0]  player_dx;
  logic        freeze;
  logic [11:0] progress;
  logic [2:0]  scroll_amt;
  logic        frame_tick;
  logic        at_end;

  int n_vec = 0;
  int n_err = 0;
  int model_prog = 0;
  int model_end  = 0;

  scroll_controller dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .playerX      (playerX),
    .player_right (player_right),
    .player_dx    (player_dx),
    .freeze       (freeze),
    .progress     (progress),
    .scroll_amt   (scroll_amt),
    .frame_tick   (frame_tick),
    .at_end       (at_end)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x;
    int right;
    int dx;
    int frz;
    int exp_amt;
    int exp_prog;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference step: smallest of overshoot, speed, 4 px and remaining world.
  function automatic int ref_step(int x, int right, int dx, int frz, int prog);
    int cand[4];
    int s;
    cand[0] = (right != 0 && x > 320) ? x - 320 : 0;
    cand[1] = dx;
    cand[2] = 4;
    cand[3] = 3200 - prog;
    s = cand[0];
    foreach (cand[i]) if (cand[i] < s) s = cand[i];
    return (frz != 0) ? 0 : s;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_prog = 0;
    model_end  = 0;
    #1;
    chk("rst_progress", int'(progress), 0);
    chk("rst_scroll_amt", int'(scroll_amt), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    chk("rst_at_end", int'(at_end), 0);
  endtask

  // One frame: edge, scrambled inputs afterwards, tick exactly 3 cycles later.
  task automatic do_frame(input int x, input int right, input int dx, input int frz,
                          input int exp_amt, input string tag);
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    playerX = 10'(x); player_right = 1'(right); player_dx = 3'(dx); freeze = 1'(frz);
    frame_clk = 1'b1;
    @(posedge Clk); #1;
    playerX = 10'($urandom); player_right = 1'($urandom); player_dx = 3'($urandom);
    freeze = 1'($urandom);
    chk({tag, "_tick_early1"}, int'(frame_tick), 0);
    @(posedge Clk); #1;
    chk({tag, "_tick_early2"}, int'(frame_tick), 0);
    @(posedge Clk); #1;
    model_prog += exp_amt;
    if (model_prog == 3200) model_end = 1;
    chk({tag, "_tick"}, int'(frame_tick), 1);
    chk({tag, "_scroll_amt"}, int'(scroll_amt), exp_amt);
    chk({tag, "_progress"}, int'(progress), model_prog);
    chk({tag, "_at_end"}, int'(at_end), model_end);
    @(posedge Clk); #1;
    chk({tag, "_tick_pulse"}, int'(frame_tick), 0);
    chk({tag, "_hold_amt"}, int'(scroll_amt), exp_amt);
  endtask

  vec_t tbl[10];

  initial begin
    int seen;
    int s;
    Reset = 1'b1; frame_clk = 1'b1; playerX = '0; player_right = 1'b0;
    player_dx = '0; freeze = 1'b0;

    // Directed table, expectations derived by hand from progress = 30.
    tbl[0] = '{322, 1, 4, 0, 2, 32};
    tbl[1] = '{400, 1, 7, 0, 4, 36};
    tbl[2] = '{330, 0, 4, 0, 0, 36};
    tbl[3] = '{321, 1, 5, 0, 1, 37};
    tbl[4] = '{320, 1, 5, 0, 0, 37};
    tbl[5] = '{500, 1, 7, 1, 0, 37};
    tbl[6] = '{600, 1, 0, 0, 0, 37};
    tbl[7] = '{1023, 1, 6, 0, 4, 41};
    tbl[8] = '{323, 1, 7, 0, 3, 44};
    tbl[9] = '{324, 1, 2, 0, 2, 46};

    do_reset();

    // Level held high through reset release must not count as an edge.
    seen = 0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (frame_tick) seen = 1;
    end
    chk("no_tick_after_reset_high", seen, 0);

    do_frame(200, 1, 3, 0, 0, "behind_line");

    for (int i = 0; i < 10; i++) do_frame(330, 1, 3, 0, 3, "push3");
    chk("progress_after_10", int'(progress), 30);

    for (int i = 0; i < 10; i++) begin
      do_frame(tbl[i].x, tbl[i].right, tbl[i].dx, tbl[i].frz, tbl[i].exp_amt, "table");
      chk("table_progress", int'(progress), tbl[i].exp_prog);
    end

    // Randomized frames against the reference model.
    for (int i = 0; i < 60; i++) begin
      int x, r, d, f;
      x = int'($urandom_range(250, 430));
      r = ($urandom_range(0, 4) != 0) ? 1 : 0;
      d = int'($urandom_range(0, 7));
      f = ($urandom_range(0, 9) == 0) ? 1 : 0;
      do_frame(x, r, d, f, ref_step(x, r, d, f, model_prog), "rand");
    end

    // Drive up to 3198 exactly, then push past the end of the world.
    while (model_prog < 3198) begin
      s = (3198 - model_prog < 4) ? 3198 - model_prog : 4;
      do_frame(1000, 1, s, 0, ref_step(1000, 1, s, 0, model_prog), "preload");
    end
    chk("preload_progress", int'(progress), 3198);
    chk("preload_not_end", int'(at_end), 0);
    do_frame(1000, 1, 4, 0, 2, "final_push");
    chk("end_progress", int'(progress), 3200);
    chk("end_flag", int'(at_end), 1);
    for (int i = 0; i < 3; i++) do_frame(1000, 1, 4, 0, 0, "past_end");
    chk("end_frozen", int'(progress), 3200);

    // Reset during COMMIT with a pending 4 px step aborts the frame.
    do_reset();
    do_frame(400, 1, 7, 0, 4, "pre_abort");
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    playerX = 10'd400; player_right = 1'b1; player_dx = 3'd7; freeze = 1'b0;
    frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_progress", int'(progress), 0);
    chk("abort_scroll_amt", int'(scroll_amt), 0);
    chk("abort_tick", int'(frame_tick), 0);
    chk("abort_at_end", int'(at_end), 0);
    @(negedge Clk);
    Reset = 1'b0;
    model_prog = 0;
    model_end  = 0;
    seen = 0;
    repeat (8) begin
      @(posedge Clk); #1;
      if (frame_tick) seen = 1;
    end
    chk("abort_no_spurious_tick", seen, 0);
    chk("abort_progress_hold", int'(progress), 0);
    do_frame(400, 1, 7, 0, 4, "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
